// File: rtl/ula_seq.sv
// ---------------------------------------------------------------------------
// ula_seq -- small sequential ALU with an optional shift-add multiplier.
//
// A request is accepted when start is high while the FSM is idle.  Operands
// and opcode are captured on that edge.  Single-cycle operations present
// their result one cycle later.  The multiply (opcode 111) takes WIDTH
// shift-add iterations and presents its result WIDTH+1 cycles after
// acceptance.
//
// Optional feature macro: ULA_MUL_EN
//   defined   -> opcode 111 is an unsigned full-width multiply
//   undefined -> opcode 111 behaves as add; no multiplier hardware
//
// Ports
//   clk      in   sole clock, rising edge
//   rst      in   asynchronous active-high reset
//   start    in   request, sampled only while idle
//   A, B     in   WIDTH-bit unsigned operands
//   seletor  in   3-bit opcode
//   busy     out  high from the cycle after acceptance through done
//   done     out  one-cycle pulse, S/cout valid in that cycle
//   S        out  2*WIDTH-bit result (upper half zero except multiply)
//   cout     out  carry / borrow / shifted-out bit, 0 for logic ops
// ---------------------------------------------------------------------------
module ula_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [2:0]         seletor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] S,
    output logic               cout
);

`ifdef ULA_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL = 2'd2} state_t;
    localparam int CW = $clog2(WIDTH + 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1} state_t;
`endif

    state_t state_reg;
    state_t state_next;

    logic             accept;
    logic             is_mul;
    // Single-cycle result; the top bit is the carry-like output.
    logic [WIDTH:0]   res_next;

`ifdef ULA_MUL_EN
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_add;
    logic [CW-1:0]      cnt_reg;

    assign is_mul  = (seletor == 3'b111);
    assign acc_add = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
`else
    assign is_mul  = 1'b0;
`endif

    assign accept = (state_reg == IDLE) && start;

    always_comb begin
        res_next = '0;
        case (seletor)
            3'b001:  res_next = {1'b0, A} - {1'b0, B};   // top bit = borrow
            3'b010:  res_next = {B[0], 1'b0, B[WIDTH-1:1]};
            3'b011:  res_next = {B[WIDTH-1], B[WIDTH-2:0], 1'b0};
            3'b100:  res_next = {1'b0, A & B};
            3'b101:  res_next = {1'b0, A | B};
            3'b110:  res_next = {1'b0, A ^ B};
            default: res_next = {1'b0, A} + {1'b0, B};   // 000, and 111 when no multiplier
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and status outputs
    always_comb begin
        state_next = state_reg;
        busy       = (state_reg != IDLE);
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = is_mul ? state_t'(2'd2) : EXEC;
                end
            end
            EXEC: begin
                done       = 1'b1;
                state_next = IDLE;
            end
`ifdef ULA_MUL_EN
            MUL: begin
                // After the last iteration the product is already on S.
                if (cnt_reg == CW'(WIDTH)) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Datapath: S/cout are written only when a final result is known, so
    // they hold between operations and never show partial products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            S    <= '0;
            cout <= 1'b0;
`ifdef ULA_MUL_EN
            mcand_reg  <= '0;
            mplier_reg <= '0;
            acc_reg    <= '0;
            cnt_reg    <= '0;
`endif
        end else if (accept && !is_mul) begin
            S    <= {{WIDTH{1'b0}}, res_next[WIDTH-1:0]};
            cout <= res_next[WIDTH];
        end
`ifdef ULA_MUL_EN
        else if (accept) begin
            mcand_reg  <= {{WIDTH{1'b0}}, A};
            mplier_reg <= B;
            acc_reg    <= '0;
            cnt_reg    <= '0;
        end else if (state_reg == MUL && cnt_reg != CW'(WIDTH)) begin
            acc_reg    <= acc_add;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + 1'b1;
            if (cnt_reg == CW'(WIDTH - 1)) begin
                S    <= acc_add;
                cout <= 1'b0;
            end
        end
`endif
    end

    // Illegal-state guard for the 2-state build uses the raw code 2'd2 above;
    // in that build it is unreachable because is_mul is constant 0.

endmodule

// File: tb/tb_ula_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_seq -- directed and randomized checks of ula_seq at WIDTH=4.
// Expected results come from a plain-arithmetic model of the opcode table.
// ---------------------------------------------------------------------------
module tb_ula_seq;
    localparam int W = 4;
    localparam int M = 1 << W;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2:0]     seletor;
    logic           busy;
    logic           done;
    logic [2*W-1:0] S;
    logic           cout;

    int vectors     = 0;
    int miscompares = 0;

    ula_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
        .seletor(seletor), .busy(busy), .done(done), .S(S), .cout(cout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: result, carry and latency straight from the opcode table.
    function automatic void model(input int a, input int b, input int sel,
                                  output int s, output int c, output int lat);
        lat = 1;
        c   = 0;
        s   = 0;
        case (sel)
            0: begin s = (a + b) % M; c = (a + b >= M) ? 1 : 0; end
            1: begin s = (a - b + M) % M; c = (a < b) ? 1 : 0; end
            2: begin s = b / 2; c = b % 2; end
            3: begin s = (b * 2) % M; c = (b >= M / 2) ? 1 : 0; end
            4: s = a & b;
            5: s = a | b;
            6: s = a ^ b;
            default: begin
`ifdef ULA_MUL_EN
                s = a * b; c = 0; lat = W + 1;
`else
                s = (a + b) % M; c = (a + b >= M) ? 1 : 0;
`endif
            end
        endcase
    endfunction

    // perturb: scramble inputs after acceptance.  hammer: hold start high
    // (with junk operands) through the whole busy period including done.
    task automatic run_op(input int a, input int b, input int sel,
                          input bit perturb, input bit hammer);
        int es, ec, el, got_lat;
        logic [2*W-1:0] prev_s;
        logic           prev_c;
        bit             seen;
        model(a, b, sel, es, ec, el);
        @(negedge clk);
        A = W'(a); B = W'(b); seletor = 3'(sel); start = 1'b1;
        prev_s = S; prev_c = cout;
        @(posedge clk); #1;
        start = hammer;
        if (hammer) begin A = 1; B = 1; seletor = 3'b000; end
        if (perturb) begin
            A = W'($urandom); B = W'($urandom); seletor = 3'($urandom);
        end
        seen = 1'b0;
        got_lat = 0;
        for (int k = 1; k <= W + 3 && !seen; k++) begin
            chk("busy", 64'(busy), 64'd1);
            if (done) begin
                seen = 1'b1;
                got_lat = k;
                chk("latency", 64'(k), 64'(el));
                chk("S", 64'(S), 64'(es));
                chk("cout", 64'(cout), 64'(ec));
            end else begin
                chk("hold_S", 64'(S), 64'(prev_s));
                chk("hold_cout", 64'(cout), 64'(prev_c));
                @(posedge clk); #1;
                if (perturb) begin
                    A = W'($urandom); B = W'($urandom); seletor = 3'($urandom);
                end
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        chk("done_single", 64'(done), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
        chk("S_keep", 64'(S), 64'(es));
        $display("op=%0d A=%0h B=%0h pert=%0d ham=%0d -> S=%0h cout=%0d lat=%0d (exp S=%0h cout=%0d lat=%0d)",
                 sel, a, b, perturb, hammer, S, cout, got_lat, es, ec, el);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = '0; B = '0; seletor = '0;
        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_S", 64'(S), 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        @(negedge clk); rst = 1'b0;

        // Directed cases
        run_op(9, 8, 0, 1'b0, 1'b0);
        run_op(3, 5, 1, 1'b0, 1'b0);
        run_op(0, 12, 3, 1'b0, 1'b0);
        run_op(0, 5, 2, 1'b0, 1'b0);
        run_op(15, 15, 7, 1'b0, 1'b0);
        run_op(15, 15, 7, 1'b0, 1'b1);   // start during busy ignored
        run_op(10, 6, 4, 1'b1, 1'b0);    // inputs scrambled after acceptance
        run_op(15, 0, 1, 1'b0, 1'b1);

        // Reset during an operation (cycle 2 of a multiply when enabled)
        @(negedge clk);
        A = 4'd13; B = 4'd11; seletor = 3'b111; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
`ifdef ULA_MUL_EN
        @(posedge clk); #1;
`endif
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_S", 64'(S), 64'd0);
        chk("abort_cout", 64'(cout), 64'd0);
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            @(posedge clk); #1;
            chk("abort_no_done", 64'(done), 64'd0);
        end
        $display("reset abort: busy=%0d S=%0h", busy, S);
        run_op(2, 2, 0, 1'b0, 1'b0);

        // Randomized
        for (int i = 0; i < 40; i++) begin
            run_op(int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                   int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 A  input  WIDTH  operand A, unsigned.
REQ-006 B  input  WIDTH  operand B, unsigned.
REQ-007 seletor  input  3  operation code, see REQ-013.
REQ-008 busy  output  1  high while an accepted operation is in progress.
REQ-009 done  output  1  single-cycle pulse; S and cout valid in that cycle.
REQ-010 S  output  2*WIDTH  result; upper WIDTH bits zero except for MUL.
REQ-011 cout  output  1  carry, borrow or shifted-out bit per REQ-013.

Function
REQ-012 The FSM SHALL have states IDLE, EXEC, MUL, with transitions: IDLE->EXEC on start with a non-MUL code; IDLE->MUL on start with code 111 when ULA_MUL_EN is defined; EXEC->IDLE after one cycle; MUL->IDLE after WIDTH iterations.
REQ-013 Opcodes SHALL be: 000 S=A+B, cout=carry; 001 S=A-B mod 2^WIDTH, cout=borrow (A<B); 010 S=B>>1, cout=B[0]; 011 S=B<<1 truncated to WIDTH, cout=B[WIDTH-1]; 100 A&B; 101 A|B; 110 A^B; 111 per REQ-023/024; cout=0 for logic ops.
REQ-014 A, B and seletor SHALL be captured on the accepting edge; later input changes SHALL NOT affect the result.
REQ-015 Single-cycle ops: done SHALL pulse exactly 1 cycle after the accepting edge (latency 1).
REQ-016 MUL: shift-add, one bit of B per cycle; done SHALL pulse WIDTH+1 cycles after the accepting edge.
REQ-017 busy SHALL be high from the cycle after acceptance through the cycle done pulses, inclusive.
REQ-018 start asserted while busy SHALL be ignored, with no queuing.
REQ-019 start in the cycle done pulses SHALL be ignored; the FSM accepts again from the next IDLE cycle.
REQ-020 S and cout SHALL hold their last result between done pulses; intermediate MUL partial products SHALL NOT appear on S.
REQ-021 done SHALL NOT be asserted for more than one consecutive cycle.

Reset
REQ-022 rst SHALL immediately force IDLE, busy=0, done=0, S=0, cout=0, aborting any operation in progress, including mid-MUL; the first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-023 With macro ULA_MUL_EN defined, opcode 111 SHALL compute the unsigned full product S=A*B (2*WIDTH bits), cout=0, with latency per REQ-016.
REQ-024 Without ULA_MUL_EN, opcode 111 SHALL behave as 000 (add, latency 1); the MUL state and multiplier datapath SHALL NOT be synthesised.

Verification (WIDTH=4)
REQ-025 start, 000, A=9, B=8 -> next cycle done=1, S=0x01, cout=1.
REQ-026 start, 001, A=3, B=5 -> next cycle S=0x0E, cout=1; then 011, B=0xC -> S=0x08, cout=1; then 010, B=0x5 -> S=0x02, cout=1.
REQ-027 ULA_MUL_EN defined, start, 111, A=15, B=15 -> busy high 5 cycles, done on cycle 5, S=0xE1, cout=0; without the macro, same stimulus -> cycle 1, S=0x0E, cout=1.
REQ-028 start pulsed again during MUL with A=1, B=1, 000 -> ignored; the MUL result 0xE1 is unchanged, and only one done pulse occurs.
REQ-029 rst asserted in cycle 2 of MUL -> busy=0, S=0 immediately; no done pulse; next start with 000, A=2, B=2 -> S=0x04.
REQ-030 Inputs changed the cycle after acceptance of 100, A=0xA, B=0x6 -> S=0x02 regardless of the changes.
